// File: rtl/muldiv_sched_pkg.sv
// Shared types, widths and helpers for the HI/LO multiply/divide sequencer.
package muldiv_sched_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;
  localparam int unsigned MULDIV_DW    = 2 * MULDIV_WIDTH;
  localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_WIDTH);

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } muldiv_state_enum;

  // Magnitude of an operand; 32'h8000_0000 maps to unsigned 2^31.
  function automatic logic [MULDIV_WIDTH-1:0] abs_val(input logic [MULDIV_WIDTH-1:0] x,
                                                      input logic                    sgn);
    return (sgn && x[MULDIV_WIDTH-1]) ? (~x + MULDIV_WIDTH'(1)) : x;
  endfunction

  // Two's-complement correction of an unsigned {HI,LO} result.
  function automatic logic [MULDIV_DW-1:0] sign_fix(input logic [MULDIV_DW-1:0] acc,
                                                    input logic                 is_div,
                                                    input logic                 neg_lo,
                                                    input logic                 neg_hi);
    logic [MULDIV_WIDTH-1:0] hi;
    logic [MULDIV_WIDTH-1:0] lo;
    if (!is_div) begin
      return neg_lo ? (~acc + MULDIV_DW'(1)) : acc;
    end
    hi = acc[MULDIV_DW-1:MULDIV_WIDTH];
    lo = acc[MULDIV_WIDTH-1:0];
    if (neg_hi) hi = ~hi + MULDIV_WIDTH'(1);
    if (neg_lo) lo = ~lo + MULDIV_WIDTH'(1);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// EXE-stage request and HI/LO write-back bundle of the multiply/divide sequencer.
interface muldiv_sched_if
  import muldiv_sched_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
);

  logic             exe_i_start;
  logic             exe_i_is_div;
  logic             exe_i_sign;
  logic [WIDTH-1:0] exe_i_src1;
  logic [WIDTH-1:0] exe_i_src2;
  logic             exe_i_flush;
  logic             stall_o;
  logic             busy_o;
  logic             hilo_we_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output exe_i_start, exe_i_is_div, exe_i_sign, exe_i_src1, exe_i_src2, exe_i_flush,
    input  stall_o, busy_o, hilo_we_o, hi_o, lo_o
  );

  modport slave (
    input  exe_i_start, exe_i_is_div, exe_i_sign, exe_i_src1, exe_i_src2, exe_i_flush,
    output stall_o, busy_o, hilo_we_o, hi_o, lo_o
  );

endinterface

// File: rtl/muldiv_core.sv
// One iteration of the multiply (add-shift) or restoring divide (compare-subtract-shift) engine.
module muldiv_core
  import muldiv_sched_pkg::*;
(
  input  logic                    is_div,
  input  logic [MULDIV_DW-1:0]    acc,
  input  logic [MULDIV_WIDTH-1:0] opnd,
  output logic [MULDIV_DW-1:0]    acc_nxt
);

  localparam int unsigned W = MULDIV_WIDTH;

  logic [W:0] part;
  logic [W:0] sum;

  // Divide: acc = {remainder, dividend/quotient}; multiply: acc = {partial, multiplier}.
  always_comb begin
    part    = '0;
    sum     = '0;
    acc_nxt = acc;
    if (is_div) begin
      part = acc[2*W-1:W-1];
      sum  = part - {1'b0, opnd};
      if (part >= {1'b0, opnd}) begin
        acc_nxt = {sum[W-1:0], acc[W-2:0], 1'b1};
      end else begin
        acc_nxt = {acc[2*W-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_nxt = {sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// MULT/MULTU/DIV/DIVU sequencer for the EXE stage; sole owner of the HI/LO write port.
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle registered multiply for MULT/MULTU.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic           cpu_clk_50M,
  input  logic           cpu_rst_n,
  muldiv_sched_if.slave  md
);

  localparam logic [MULDIV_CNT_W-1:0] CNT_LAST = MULDIV_CNT_W'(WIDTH - 1);

  muldiv_state_enum          state_q, state_d;
  logic [MULDIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic [MULDIV_DW-1:0]      acc_q, acc_d;
  logic [MULDIV_WIDTH-1:0]   opnd_q, opnd_d;
  logic                      is_div_q, is_div_d;
  logic                      neg_lo_q, neg_lo_d;
  logic                      neg_hi_q, neg_hi_d;
  logic [MULDIV_WIDTH-1:0]   hi_q, hi_d;
  logic [MULDIV_WIDTH-1:0]   lo_q, lo_d;
  logic                      stall_c;
  logic                      we_c;

  logic [MULDIV_WIDTH-1:0]   src1_abs;
  logic [MULDIV_WIDTH-1:0]   src2_abs;
  logic                      start_neg_lo;
  logic                      start_neg_hi;
  logic [MULDIV_DW-1:0]      acc_nxt;

  assign src1_abs     = abs_val(md.exe_i_src1, md.exe_i_sign);
  assign src2_abs     = abs_val(md.exe_i_src2, md.exe_i_sign);
  assign start_neg_lo = md.exe_i_sign & (md.exe_i_src1[MULDIV_WIDTH-1] ^ md.exe_i_src2[MULDIV_WIDTH-1]);
  assign start_neg_hi = md.exe_i_sign & md.exe_i_src1[MULDIV_WIDTH-1];

`ifdef MULDIV_FAST_MULT_EN
  logic [MULDIV_DW-1:0] prod_abs;
  assign prod_abs = MULDIV_DW'(src1_abs) * MULDIV_DW'(src2_abs);
`endif

  muldiv_core u_core (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_nxt)
  );

  // State and iteration counter.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand/accumulator latches, sign flags and HI/LO output registers.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state, datapath updates, stall and write strobe; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stall_c  = 1'b0;
    we_c     = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (md.exe_i_start) begin
          stall_c  = 1'b1;
          acc_d    = {MULDIV_WIDTH'(0), src1_abs};
          opnd_d   = src2_abs;
          is_div_d = md.exe_i_is_div;
          neg_lo_d = start_neg_lo;
          neg_hi_d = start_neg_hi;
          cnt_d    = '0;
          state_d  = MD_CALC;
`ifdef MULDIV_FAST_MULT_EN
          if (!md.exe_i_is_div) begin
            {hi_d, lo_d} = sign_fix(prod_abs, 1'b0, start_neg_lo, 1'b0);
            state_d      = MD_DONE;
          end
`endif
        end
      end
      MD_CALC: begin
        stall_c = 1'b1;
        acc_d   = acc_nxt;
        cnt_d   = cnt_q + MULDIV_CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          {hi_d, lo_d} = sign_fix(acc_nxt, is_div_q, neg_lo_q, neg_hi_q);
          state_d      = MD_DONE;
        end
      end
      MD_DONE: begin
        we_c    = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    if (md.exe_i_flush) begin
      state_d = MD_IDLE;
      stall_c = 1'b0;
      we_c    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  assign md.stall_o   = stall_c;
  assign md.busy_o    = (state_q != MD_IDLE);
  assign md.hilo_we_o = we_c;
  assign md.hi_o      = hi_q;
  assign md.lo_o      = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed table, flush/reset sequences, random ops vs. arithmetic model.
module tb_muldiv_sched;
  import muldiv_sched_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MULT_STALL = 1;
`else
  localparam int MULT_STALL = 33;
`endif
  localparam int DIV_STALL = 33;

  typedef struct {
    logic        d;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_sched_if bus ();

  muldiv_sched dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .md          (bus)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference results from plain arithmetic: {hi, lo}.
  function automatic logic [63:0] ref_model(input logic d, input logic s,
                                             input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!d) begin
      if (s) return 64'(sa * sb);
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Issue one op, hold start while stalled, scramble operands after the start cycle, check the strobe.
  task automatic do_op(input vec_t v, input string nm, output int we_at);
    int stalls;
    int exp_stall;
    bit got;
    exp_stall = v.d ? DIV_STALL : MULT_STALL;
    @(negedge clk);
    bus.exe_i_start  = 1'b1;
    bus.exe_i_is_div = v.d;
    bus.exe_i_sign   = v.s;
    bus.exe_i_src1   = v.a;
    bus.exe_i_src2   = v.b;
    bus.exe_i_flush  = 1'b0;
    stalls = 0;
    got    = 1'b0;
    we_at  = -1;
    for (int c = 0; c < 80 && !got; c++) begin
      #1;
      if (bus.hilo_we_o) begin
        got   = 1'b1;
        we_at = cyc;
        check({nm, " stall_cycles"}, 64'(stalls), 64'(exp_stall));
        check({nm, " stall_in_done"}, 64'(bus.stall_o), 64'd0);
        check({nm, " hi"}, 64'(bus.hi_o), 64'(v.hi));
        check({nm, " lo"}, 64'(bus.lo_o), 64'(v.lo));
        bus.exe_i_start = 1'b0;
      end else begin
        if (bus.stall_o) stalls++;
        if (c == 1 && exp_stall > 1) check({nm, " busy_calc"}, 64'(bus.busy_o), 64'd1);
        @(negedge clk);
        if (c == 0) begin
          bus.exe_i_src1 = $urandom;
          bus.exe_i_src2 = $urandom;
        end
      end
    end
    if (!got) begin
      check({nm, " strobe_timeout"}, 64'd0, 64'd1);
      bus.exe_i_start = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick_opnd();
    logic [31:0] corners [4];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h8000_0000;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h0000_0001;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 255));
    return $urandom;
  endfunction

  vec_t        tbl [12];
  vec_t        v;
  int          w0, w1;
  int          we_seen;
  logic [63:0] saved;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
    tbl[1]  = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{1'b1, 1'b0, 32'd100,       32'd7,          32'd2,         32'd14};
    tbl[4]  = '{1'b1, 1'b0, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
    tbl[5]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    tbl[6]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0};
    tbl[7]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1};
    tbl[8]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'd1};
    tbl[9]  = '{1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
    tbl[10] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    tbl[11] = '{1'b1, 1'b1, 32'h8000_0000, 32'd2,          32'd0,         32'hC000_0000};

    bus.exe_i_start  = 1'b0;
    bus.exe_i_is_div = 1'b0;
    bus.exe_i_sign   = 1'b0;
    bus.exe_i_src1   = '0;
    bus.exe_i_src2   = '0;
    bus.exe_i_flush  = 1'b0;

    // Reset values.
    #1;
    check("reset_ctrl", 64'({bus.stall_o, bus.busy_o, bus.hilo_we_o}), 64'd0);
    check("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table, issued back to back.
    foreach (tbl[i]) do_op(tbl[i], $sformatf("vec%0d", i), w0);

    // Outputs hold after the strobe.
    saved = {tbl[11].hi, tbl[11].lo};
    @(negedge clk);
    #1;
    check("hold_we", 64'(bus.hilo_we_o), 64'd0);
    check("hold_hilo", {bus.hi_o, bus.lo_o}, saved);

    // Back-to-back MULT then DIV: strobes 34 cycles apart.
    do_op(tbl[1], "b2b_mult", w0);
    do_op(tbl[3], "b2b_div", w1);
    check("b2b_spacing", 64'(w1 - w0), 64'd34);
    saved = {tbl[3].hi, tbl[3].lo};

    // Flush in CALC cycle 10.
    @(negedge clk);
    bus.exe_i_start  = 1'b1;
    bus.exe_i_is_div = 1'b1;
    bus.exe_i_sign   = 1'b1;
    bus.exe_i_src1   = 32'hFFFF_FFF9;
    bus.exe_i_src2   = 32'd2;
    repeat (11) @(negedge clk);
    bus.exe_i_flush = 1'b1;
    #1;
    check("flush_stall", 64'(bus.stall_o), 64'd0);
    check("flush_busy_before", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    bus.exe_i_flush = 1'b0;
    bus.exe_i_start = 1'b0;
    #1;
    check("flush_idle", 64'({bus.busy_o, bus.stall_o}), 64'd0);
    we_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.hilo_we_o) we_seen++;
    end
    check("flush_no_strobe", 64'(we_seen), 64'd0);
    check("flush_hilo_kept", {bus.hi_o, bus.lo_o}, saved);

    // Flush wins over start in IDLE.
    @(negedge clk);
    bus.exe_i_start = 1'b1;
    bus.exe_i_flush = 1'b1;
    #1;
    check("flush_start_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    bus.exe_i_start = 1'b0;
    bus.exe_i_flush = 1'b0;
    #1;
    check("flush_start_busy", 64'(bus.busy_o), 64'd0);

    // Reset mid-op drops the op and clears outputs.
    @(negedge clk);
    bus.exe_i_start  = 1'b1;
    bus.exe_i_is_div = 1'b1;
    bus.exe_i_sign   = 1'b0;
    bus.exe_i_src1   = 32'd100;
    bus.exe_i_src2   = 32'd7;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    bus.exe_i_start = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({bus.stall_o, bus.busy_o, bus.hilo_we_o}), 64'd0);
    check("rst_mid_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    we_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.hilo_we_o || bus.busy_o) we_seen++;
    end
    check("rst_mid_quiet", 64'(we_seen), 64'd0);

    // Random ops against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      v.d = 1'($urandom_range(0, 1));
      v.s = 1'($urandom_range(0, 1));
      v.a = pick_opnd();
      v.b = pick_opnd();
      {v.hi, v.lo} = ref_model(v.d, v.s, v.a, v.b);
      do_op(v, $sformatf("rnd%0d %s%s %h %h", n, v.d ? "div" : "mul", v.s ? "" : "u", v.a, v.b), w0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
